// File: rtl/uart_ts_pkg.sv
// Shared types and constants for the UART timestamp event path.
// Holds the arbiter FSM state, line size and channel-index width helper.
package uart_ts_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  localparam int LINE_BYTES = 56;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_ev_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr,
// wrapping modulo N. Ports: req, ptr in; gnt_onehot, gnt_idx, any out.
module rr_pick
  import uart_ts_pkg::*;
#(
  parameter int N = 4,
  parameter int W = ch_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt_onehot,
  output logic [W-1:0] gnt_idx,
  output logic         any
);

  int j;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    j          = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any           = 1'b1;
        gnt_idx       = W'(j);
        gnt_onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_ev_arbiter.sv
// Round-robin arbiter feeding one timestamp event at a time to the packer.
// In: clk, rst, enable, in_valid/id/start/end/delta, ev_ready, fifo_prog_full.
// Out: in_ready, ev_valid/id/start/end/delta/chan, busy, stall_cnt.
module uart_ev_arbiter
  import uart_ts_pkg::*;
#(
  parameter  int N_CH = 4,
  parameter  int TS_W = 64,
  parameter  int ID_W = 16,
  localparam int CH_W = ch_w(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [N_CH-1:0]      in_valid,
  output logic [N_CH-1:0]      in_ready,
  input  logic [N_CH*ID_W-1:0] in_id,
  input  logic [N_CH*TS_W-1:0] in_start,
  input  logic [N_CH*TS_W-1:0] in_end,
  input  logic [N_CH*TS_W-1:0] in_delta,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [ID_W-1:0]      ev_id,
  output logic [TS_W-1:0]      ev_start,
  output logic [TS_W-1:0]      ev_end,
  output logic [TS_W-1:0]      ev_delta,
  output logic [CH_W-1:0]      ev_chan,
  input  logic                 fifo_prog_full,
  output logic                 busy,
  output logic [15:0]          stall_cnt
);

  state_t            state_q;
  logic              ev_valid_q;
  logic [ID_W-1:0]   ev_id_q;
  logic [TS_W-1:0]   ev_start_q;
  logic [TS_W-1:0]   ev_end_q;
  logic [TS_W-1:0]   ev_delta_q;
  logic [CH_W-1:0]   ev_chan_q;
  logic [CH_W-1:0]   rr_ptr_q;
  logic [CH_W-1:0]   rr_ptr_d;
  logic [15:0]       stall_q;

  logic [N_CH-1:0]   gnt_oh;
  logic [CH_W-1:0]   gnt_idx;
  logic              any_req;
  logic              grant_ok;

  rr_pick #(
    .N (N_CH),
    .W (CH_W)
  ) u_pick (
    .req        (in_valid),
    .ptr        (rr_ptr_q),
    .gnt_onehot (gnt_oh),
    .gnt_idx    (gnt_idx),
    .any        (any_req)
  );

  assign grant_ok = (state_q == IDLE) && enable
                  && !fifo_prog_full && !rst;
  assign in_ready = grant_ok ? gnt_oh : '0;

  // explicit wrap keeps non-power-of-two channel counts in range
  always_comb begin
    rr_ptr_d = ev_chan_q + 1'b1;
    if (ev_chan_q == CH_W'(N_CH - 1)) rr_ptr_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ev_valid_q <= 1'b0;
      ev_id_q    <= '0;
      ev_start_q <= '0;
      ev_end_q   <= '0;
      ev_delta_q <= '0;
      ev_chan_q  <= '0;
      rr_ptr_q   <= '0;
      stall_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable && any_req) begin
            if (fifo_prog_full) begin
              if (stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
            end else begin
              ev_id_q    <= in_id[int'(gnt_idx)*ID_W +: ID_W];
              ev_start_q <= in_start[int'(gnt_idx)*TS_W +: TS_W];
              ev_end_q   <= in_end[int'(gnt_idx)*TS_W +: TS_W];
              ev_delta_q <= in_delta[int'(gnt_idx)*TS_W +: TS_W];
              ev_chan_q  <= gnt_idx;
              ev_valid_q <= 1'b1;
              state_q    <= OFFER;
            end
          end
        end
        OFFER: begin
          if (ev_ready) begin
            ev_valid_q <= 1'b0;
            rr_ptr_q   <= rr_ptr_d;
            state_q    <= IDLE;
          end
        end
      endcase
    end
  end

  assign ev_valid  = ev_valid_q;
  assign ev_id     = ev_id_q;
  assign ev_start  = ev_start_q;
  assign ev_end    = ev_end_q;
  assign ev_delta  = ev_delta_q;
  assign ev_chan   = ev_chan_q;
  assign busy      = (state_q == OFFER);
  assign stall_cnt = stall_q;

endmodule

// File: doc/uart_ev_arbiter.md
UART_EV_ARBITER -- requirements
Module: uart_ev_arbiter

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, giving the number of event requester channels (2..8).
REQ-002 The block SHALL have parameter TS_W, default 64, giving the timestamp width.
REQ-003 The block SHALL have parameter ID_W, default 16, giving the event ID width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; every register samples on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port enable, input, 1 bit: arbitration enable; 0 blocks new grants.
REQ-007 The block SHALL have port in_valid, input, N_CH bits: per-channel event valid.
REQ-008 The block SHALL have port in_ready, output, N_CH bits: per-channel accept, one-hot or zero.
REQ-009 The block SHALL have port in_id, input, N_CH*ID_W bits: flattened IDs; channel k occupies bits [k*ID_W +: ID_W].
REQ-010 The block SHALL have ports in_start, in_end and in_delta, input, N_CH*TS_W bits each: flattened timestamps, packed the same way as in_id.
REQ-011 The block SHALL have port ev_valid, output, 1 bit: event offered to the packer.
REQ-012 The block SHALL have port ev_ready, input, 1 bit: packer accepts the offered event.
REQ-013 The block SHALL have ports ev_id, output, ID_W bits, and ev_start, ev_end and ev_delta, output, TS_W bits each: the registered payload.
REQ-014 The block SHALL have port ev_chan, output, CH_W = max(1, clog2(N_CH)) bits: source channel of the offered event.
REQ-015 The block SHALL have port fifo_prog_full, input, 1 bit: byte FIFO cannot reserve a full 56-byte line.
REQ-016 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-017 The block SHALL have port stall_cnt, output, 16 bits: saturating count of cycles blocked by fifo_prog_full.

Function
REQ-018 The FSM SHALL have two states, IDLE and OFFER.
REQ-019 A grant SHALL be made in IDLE when enable=1, fifo_prog_full=0 and in_valid is nonzero.
- Winner: first set in_valid bit, searching upward from rr_ptr and wrapping modulo N_CH.
REQ-020 On the grant cycle, in_ready SHALL be high only for the winner (combinational from in_valid and state); this cycle is the input handshake.
REQ-021 On the grant edge, the block SHALL:
- register the winner's id/start/end/delta into ev_* and the winner's index into ev_chan;
- set ev_valid=1 and move to OFFER.
- Latency from in_valid to ev_valid is 1 cycle.
REQ-022 In OFFER, ev_valid and ev_* SHALL stay stable until ev_valid and ev_ready are both high.
REQ-023 On the output handshake, the block SHALL clear ev_valid, set rr_ptr = (ev_chan+1) mod N_CH and return to IDLE.
- Minimum spacing between grants is 2 cycles.
REQ-024 In OFFER, in_ready SHALL be all zeros.
REQ-025 Changes to enable or fifo_prog_full during OFFER SHALL NOT withdraw the offered event.
REQ-026 stall_cnt SHALL increment by 1 in each IDLE cycle with enable=1, in_valid nonzero and fifo_prog_full=1, and SHALL saturate at 16'hFFFF.
REQ-027 A channel dropping in_valid before it is granted SHALL NOT be captured.
REQ-028 When N_CH is not a power of two, the rr_ptr increment SHALL wrap explicitly to 0.

Reset
REQ-029 rst SHALL set state=IDLE, ev_valid=0, ev_id/ev_start/ev_end/ev_delta=0, ev_chan=0, rr_ptr=0, stall_cnt=0 and busy=0.
REQ-030 in_ready SHALL be all zeros while rst=1.
REQ-031 Reset during OFFER SHALL discard the held event, which is not re-offered.

Structure
REQ-032 Shared package uart_ts_pkg SHALL hold the arbiter state_t enum, the LINE_BYTES=56 constant and the CH_W width function.
REQ-033 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs req, ptr; outputs gnt_onehot, gnt_idx, any).

Verification
REQ-034 The bench SHALL cover: all 4 channels valid with IDs 0x000A..0x000D and ev_ready tied 1 -> ev_chan order 0,1,2,3,0; each in_ready is a single-cycle pulse.
REQ-035 The bench SHALL cover: ch2 valid with start=64'h1, ev_ready held 0 for 10 cycles -> ev_valid and ev_start stable for all 10 cycles, in_ready=0 throughout, handshake on cycle 11.
REQ-036 The bench SHALL cover: fifo_prog_full=1 for 5 cycles with ch1 valid -> no grant, stall_cnt=5, grant on the first cycle after deassertion.
REQ-037 The bench SHALL cover: fifo_prog_full rising during OFFER -> the event is still delivered and no new grant occurs until it falls.
REQ-038 The bench SHALL cover: rst asserted in OFFER -> ev_valid=0 the next cycle, rr_ptr=0, and the next grant goes to the lowest valid channel.
REQ-039 The bench SHALL cover: N_CH=3 with all channels valid -> wrap order 0,1,2,0; force stall_cnt to 16'hFFFE, add 3 stall cycles -> stall_cnt reads 16'hFFFF.
